lcd1602_responder: RTL

HD44780-compatible bus responder for the LCD1602 path: it plays the display end of the RS/RW/EN/DATA bus and replaces the panel in simulation and on-chip loopback. It decodes the controller's 8-bit instruction and data writes, and holds the display and cursor state. It stores an 80-byte DDRAM and answers status and data reads. A monitor port exposes DDRAM contents so a bench or debug logic can check what the controller wrote.

---
 rtl/lcd1602_responder.sv | 273 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/lcd1602_responder.sv
// rtl/lcd1602_responder.sv - HD44780-style display-end bus responder with 80-byte DDRAM
// Decodes controller writes and reads, tracks cursor/display state, exposes DDRAM on a monitor port.
module lcd1602_responder #(
  parameter int BUSY_CYC  = 100,
  parameter int BUSY_LONG = 1000
) (
  input  logic       iclk,
  input  logic       irst,
  input  logic       LCD_EN,
  input  logic       LCD_RS,
  input  logic       LCD_RW,
  input  logic [7:0] LCD_DATA,
  output logic [7:0] LCD_DOUT,
  output logic       LCD_DOE,
  input  logic [6:0] mon_addr,
  output logic [7:0] mon_data,
  output logic [6:0] ac,
  output logic       busy,
  output logic       disp_on,
  output logic       cur_on,
  output logic       blink_on,
  output logic [5:0] shift_ofs,
  output logic       cmd_valid,
  output logic       proto_err
);

  localparam logic [2:0] ST_RESET_FILL = 3'd0;
  localparam logic [2:0] ST_IDLE       = 3'd1;
  localparam logic [2:0] ST_EXEC       = 3'd2;
  localparam logic [2:0] ST_FILL       = 3'd3;
  localparam logic [2:0] ST_BUSY_WAIT  = 3'd4;

  localparam int         CW    = $clog2(BUSY_LONG + 1);
  localparam logic [7:0] BLANK = 8'h20;

  function automatic logic addr_ok(input logic [6:0] a);
    return (a <= 7'h27) || (a >= 7'h40 && a <= 7'h67);
  endfunction

  // Second display line (0x40..0x67) lives at linear slots 40..79.
  function automatic logic [6:0] mem_idx(input logic [6:0] a);
    return a[6] ? (7'd40 + {1'b0, a[5:0]}) : a;
  endfunction

  function automatic logic [6:0] ac_step(input logic [6:0] a, input logic up);
    if (up) begin
      if (a == 7'h27)      return 7'h40;
      else if (a == 7'h67) return 7'h00;
      else                 return a + 7'd1;
    end else begin
      if (a == 7'h00)      return 7'h67;
      else if (a == 7'h40) return 7'h27;
      else                 return a - 7'd1;
    end
  endfunction

  function automatic logic [5:0] ofs_step(input logic [5:0] s, input logic up);
    if (up) return (s == 6'd39) ? 6'd0 : s + 6'd1;
    else    return (s == 6'd0) ? 6'd39 : s - 6'd1;
  endfunction

  logic          en_s1_q, en_s2_q, en_h_q;
  logic          rs_d1_q, rs_d2_q, rw_d1_q, rw_d2_q;
  logic [7:0]    data_d1_q, data_d2_q;

  logic [2:0]    state_q, state_d;
  logic [6:0]    ac_q, ac_d;
  logic          id_q, id_d, s_q, s_d;
  logic          disp_q, disp_d, cur_q, cur_d, blink_q, blink_d;
  logic [5:0]    shift_q, shift_d;
  logic          cgram_q, cgram_d;
  logic          busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [6:0]    fill_q, fill_d;
  logic          cmd_valid_q, cmd_valid_d, proto_err_q, proto_err_d;

  logic [7:0]    ddram_q [0:79];
  logic [7:0]    mon_data_q;
  logic          we;
  logic [6:0]    widx;
  logic [7:0]    wdata;
  logic          commit, accept, long_busy, do_clear;
  logic [7:0]    rd_byte;

  assign commit = ~en_s2_q & en_h_q;

  always_comb begin
    state_d     = state_q;
    ac_d        = ac_q;
    id_d        = id_q;
    s_d         = s_q;
    disp_d      = disp_q;
    cur_d       = cur_q;
    blink_d     = blink_q;
    shift_d     = shift_q;
    cgram_d     = cgram_q;
    busy_d      = busy_q;
    cnt_d       = cnt_q;
    fill_d      = fill_q;
    cmd_valid_d = 1'b0;
    proto_err_d = 1'b0;
    we          = 1'b0;
    widx        = mem_idx(ac_q);
    wdata       = data_d2_q;
    accept      = 1'b0;
    long_busy   = 1'b0;
    do_clear    = 1'b0;

    if (busy_q) begin
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) busy_d = 1'b0;
    end

    case (state_q)
      ST_RESET_FILL, ST_FILL: begin
        we    = 1'b1;
        widx  = fill_q;
        wdata = BLANK;
        if (fill_q == 7'd79) state_d = ST_BUSY_WAIT;
        else                 fill_d  = fill_q + 7'd1;
      end
      ST_EXEC:      state_d = ST_BUSY_WAIT;
      ST_BUSY_WAIT: if (!busy_q) state_d = ST_IDLE;
      default: ;
    endcase

    if (commit) begin
      if (!rs_d2_q && rw_d2_q) begin
        cmd_valid_d = 1'b1;
      end else if (busy_q) begin
        proto_err_d = 1'b1;
      end else begin
        accept = 1'b1;
        if (rs_d2_q) begin
          // CGRAM contents are not modelled: data traffic there is swallowed.
          if (!cgram_q) begin
            if (!rw_d2_q) begin
              we    = 1'b1;
              widx  = mem_idx(ac_q);
              wdata = data_d2_q;
              if (s_q) shift_d = ofs_step(shift_q, id_q);
            end
            ac_d = ac_step(ac_q, id_q);
          end
        end else begin
          casez (data_d2_q)
            8'b1???????: begin
              if (addr_ok(data_d2_q[6:0])) begin
                ac_d    = data_d2_q[6:0];
                cgram_d = 1'b0;
              end else begin
                accept = 1'b0;
              end
            end
            8'b01??????: cgram_d = 1'b1;
            8'b001?????: if (!data_d2_q[4]) accept = 1'b0;
            8'b0001????: begin
              if (data_d2_q[3]) shift_d = ofs_step(shift_q, data_d2_q[2]);
              else              ac_d    = ac_step(ac_q, data_d2_q[2]);
            end
            8'b00001???: begin
              disp_d  = data_d2_q[2];
              cur_d   = data_d2_q[1];
              blink_d = data_d2_q[0];
            end
            8'b000001??: begin
              id_d = data_d2_q[1];
              s_d  = data_d2_q[0];
            end
            8'b0000001?: begin
              ac_d      = 7'h00;
              shift_d   = 6'd0;
              long_busy = 1'b1;
            end
            8'b00000001: begin
              ac_d      = 7'h00;
              id_d      = 1'b1;
              shift_d   = 6'd0;
              long_busy = 1'b1;
              do_clear  = 1'b1;
            end
            default: accept = 1'b0;
          endcase
        end

        if (accept) begin
          cmd_valid_d = 1'b1;
          busy_d      = 1'b1;
          cnt_d       = long_busy ? CW'(BUSY_LONG) : CW'(BUSY_CYC);
          if (do_clear) begin
            state_d = ST_FILL;
            fill_d  = 7'd0;
          end else begin
            state_d = ST_EXEC;
          end
        end else begin
          proto_err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      en_s1_q     <= 1'b0;
      en_s2_q     <= 1'b0;
      en_h_q      <= 1'b0;
      rs_d1_q     <= 1'b0;
      rs_d2_q     <= 1'b0;
      rw_d1_q     <= 1'b0;
      rw_d2_q     <= 1'b0;
      data_d1_q   <= 8'h00;
      data_d2_q   <= 8'h00;
      state_q     <= ST_RESET_FILL;
      ac_q        <= 7'h00;
      id_q        <= 1'b1;
      s_q         <= 1'b0;
      disp_q      <= 1'b0;
      cur_q       <= 1'b0;
      blink_q     <= 1'b0;
      shift_q     <= 6'd0;
      cgram_q     <= 1'b0;
      busy_q      <= 1'b1;
      cnt_q       <= CW'(BUSY_LONG);
      fill_q      <= 7'd0;
      cmd_valid_q <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      en_s1_q     <= LCD_EN;
      en_s2_q     <= en_s1_q;
      en_h_q      <= en_s2_q;
      rs_d1_q     <= LCD_RS;
      rs_d2_q     <= rs_d1_q;
      rw_d1_q     <= LCD_RW;
      rw_d2_q     <= rw_d1_q;
      data_d1_q   <= LCD_DATA;
      data_d2_q   <= data_d1_q;
      state_q     <= state_d;
      ac_q        <= ac_d;
      id_q        <= id_d;
      s_q         <= s_d;
      disp_q      <= disp_d;
      cur_q       <= cur_d;
      blink_q     <= blink_d;
      shift_q     <= shift_d;
      cgram_q     <= cgram_d;
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
      fill_q      <= fill_d;
      cmd_valid_q <= cmd_valid_d;
      proto_err_q <= proto_err_d;
    end
  end

  always_ff @(posedge iclk) begin
    if (we) ddram_q[widx] <= wdata;
    mon_data_q <= addr_ok(mon_addr) ? ddram_q[mem_idx(mon_addr)] : 8'h00;
  end

  assign rd_byte   = cgram_q ? 8'h00 : ddram_q[mem_idx(ac_q)];
  assign LCD_DOE   = en_s2_q & rw_d2_q;
  assign LCD_DOUT  = LCD_DOE ? (rs_d2_q ? rd_byte : {busy_q, ac_q}) : 8'h00;
  assign mon_data  = mon_data_q;
  assign ac        = ac_q;
  assign busy      = busy_q;
  assign disp_on   = disp_q;
  assign cur_on    = cur_q;
  assign blink_on  = blink_q;
  assign shift_ofs = shift_q;
  assign cmd_valid = cmd_valid_q;
  assign proto_err = proto_err_q;

endmodule
